// File: rtl/pio_write_arbiter.sv
// rtl/pio_write_arbiter.sv - round-robin arbiter sharing the PIO write port with masked RMW against a shadow register
module pio_write_arbiter #(
    parameter int          N_REQ     = 2,
    parameter int          GAP       = 1,
    parameter logic [31:0] RESET_VAL = 32'h0000_00A8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  wdata,
    input  logic [32*N_REQ-1:0]  wmask,
    output logic [N_REQ-1:0]     ack,
    output logic                 pio_en,
    output logic [31:0]          pio_data,
    output logic [31:0]          shadow,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t      state, next_state;
    logic [1:0]  rr_ptr;
    logic [3:0]  gap_cnt;
    logic [3:0]  req_ext;
    logic [1:0]  win;
    logic        any_req;
    logic [2:0]  scan_sum;
    logic [1:0]  scan_idx;
    logic [31:0] merged;
    logic [3:0]  ack_full;
    logic [31:0] wd_arr [4];
    logic [31:0] wm_arr [4];

    assign req_ext = 4'(req);

    // Unused requester slots read as zero so the 2-bit winner index never selects garbage.
    for (genvar g = 0; g < 4; g++) begin : g_slot
        if (g < N_REQ) begin : g_used
            assign wd_arr[g] = wdata[32*g +: 32];
            assign wm_arr[g] = wmask[32*g +: 32];
        end else begin : g_unused
            assign wd_arr[g] = 32'h0;
            assign wm_arr[g] = 32'h0;
        end
    end

    // Scan upward from the rotation pointer, wrapping modulo N_REQ.
    always_comb begin
        any_req  = 1'b0;
        win      = 2'd0;
        scan_sum = 3'd0;
        scan_idx = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + 3'(i);
            if (scan_sum >= 3'(N_REQ))
                scan_sum = scan_sum - 3'(N_REQ);
            scan_idx = scan_sum[1:0];
            if (!any_req && req_ext[scan_idx]) begin
                any_req = 1'b1;
                win     = scan_idx;
            end
        end
    end

    assign merged = (shadow & ~wm_arr[win]) | (wd_arr[win] & wm_arr[win]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (any_req) next_state = S_ISSUE;
            S_ISSUE: next_state = (GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (gap_cnt == 4'(GAP - 1)) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        pio_en   = 1'b0;
        busy     = 1'b0;
        ack_full = 4'b0000;
        case (state)
            S_ISSUE: begin
                pio_en   = 1'b1;
                busy     = 1'b1;
                ack_full = 4'b0001 << grant_id;
            end
            S_GAP:   busy = 1'b1;
            default: ;
        endcase
    end

    assign ack = ack_full[N_REQ-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= RESET_VAL;
            pio_data <= RESET_VAL;
            grant_id <= 2'd0;
            rr_ptr   <= 2'd0;
            gap_cnt  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_id <= win;
                        pio_data <= merged;
                    end
                end
                S_ISSUE: begin
                    shadow  <= pio_data;
                    rr_ptr  <= (grant_id == 2'(N_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
                    gap_cnt <= 4'd0;
                end
                S_GAP:   gap_cnt <= gap_cnt + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// tb/tb_pio_write_arbiter.sv - directed self-checking bench for pio_write_arbiter
module tb_pio_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [63:0] wdata = 64'h0;
    logic [63:0] wmask = 64'h0;
    logic [1:0]  ack;
    logic        pio_en;
    logic [31:0] pio_data;
    logic [31:0] shadow;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    pio_write_arbiter #(.N_REQ(2), .GAP(1), .RESET_VAL(32'h0000_00A8)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .wmask(wmask),
        .ack(ack), .pio_en(pio_en), .pio_data(pio_data), .shadow(shadow),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b00;
        repeat (2) step();
        rst = 1'b0;
        step();
        checks++; if (shadow !== 32'h0000_00A8) begin errors++; $display("FAIL reset_shadow got %h exp %h", shadow, 32'h0000_00A8); end
        checks++; if (pio_data !== 32'h0000_00A8) begin errors++; $display("FAIL reset_pio_data got %h exp %h", pio_data, 32'h0000_00A8); end
        checks++; if ({pio_en, ack, busy} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {pio_en, ack, busy}); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    endtask

    task automatic test_single_write();
        wdata[31:0] = 32'h0000_0003;
        wmask[31:0] = 32'h0000_0003;
        req = 2'b01;
        step();
        req = 2'b00;
        checks++; if ({pio_en, ack} !== 3'b101) begin errors++; $display("FAIL single_en_ack got %b exp 101", {pio_en, ack}); end
        checks++; if (pio_data !== 32'h0000_00AB) begin errors++; $display("FAIL single_pio_data got %h exp %h", pio_data, 32'h0000_00AB); end
        step();
        checks++; if ({pio_en, busy} !== 2'b01) begin errors++; $display("FAIL single_gap got %b exp 01", {pio_en, busy}); end
        checks++; if (shadow !== 32'h0000_00AB) begin errors++; $display("FAIL single_shadow got %h exp %h", shadow, 32'h0000_00AB); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
    endtask

    task automatic test_field_isolation();
        wdata[63:32] = 32'hFFFF_FFFF;
        wmask[63:32] = 32'h0000_03FC;
        req = 2'b10;
        step();
        req = 2'b00;
        checks++; if ({pio_en, ack} !== 3'b110) begin errors++; $display("FAIL field_en_ack got %b exp 110", {pio_en, ack}); end
        checks++; if (pio_data !== 32'h0000_03FF) begin errors++; $display("FAIL field_pio_data got %h exp %h", pio_data, 32'h0000_03FF); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL field_grant got %0d exp 1", grant_id); end
        repeat (2) step();
        checks++; if (shadow !== 32'h0000_03FF) begin errors++; $display("FAIL field_shadow got %h exp %h", shadow, 32'h0000_03FF); end
    endtask

    task automatic test_contention();
        logic       exp_en;
        logic [1:0] exp_ack;
        wdata = {32'h0000_5555, 32'hAAAA_0000};
        wmask = {32'h0000_FFFF, 32'hFFFF_0000};
        req = 2'b11;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 11) req = 2'b00;
            exp_en  = (k % 3 == 0);
            exp_ack = exp_en ? (((k / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({pio_en, ack} !== {exp_en, exp_ack}) begin
                errors++;
                $display("FAIL contention_cycle%0d got %b exp %b", k, {pio_en, ack}, {exp_en, exp_ack});
            end
        end
        repeat (3) step();
        checks++; if (shadow !== 32'hAAAA_5555) begin errors++; $display("FAIL contention_shadow got %h exp %h", shadow, 32'hAAAA_5555); end
    endtask

    task automatic test_reset_mid_issue();
        int late_acks = 0;
        wdata[31:0] = 32'hDEAD_BEEF;
        wmask[31:0] = 32'hFFFF_FFFF;
        req = 2'b01;
        step();
        checks++; if (pio_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre_en got %b exp 1", pio_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({pio_en, ack, busy} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctrl got %b exp 0000", {pio_en, ack, busy}); end
        checks++; if (shadow !== 32'h0000_00A8) begin errors++; $display("FAIL rstmid_shadow got %h exp %h", shadow, 32'h0000_00A8); end
        checks++; if (pio_data !== 32'h0000_00A8) begin errors++; $display("FAIL rstmid_pio_data got %h exp %h", pio_data, 32'h0000_00A8); end
        req = 2'b00;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ack !== 2'b00 || pio_en !== 1'b0) late_acks++;
        end
        checks++; if (late_acks !== 0) begin errors++; $display("FAIL rstmid_late_ack got %0d exp 0", late_acks); end
        checks++; if (shadow !== 32'h0000_00A8) begin errors++; $display("FAIL rstmid_shadow_after got %h exp %h", shadow, 32'h0000_00A8); end
    endtask

    task automatic test_request_withdrawn();
        int extra = 0;
        wdata[31:0] = 32'h0000_0001;
        wmask[31:0] = 32'h0000_0001;
        req = 2'b01;
        step();
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL withdraw_ack0 got %b exp 01", ack); end
        req = 2'b10;
        step();
        req = 2'b00;
        for (int k = 0; k < 6; k++) begin
            step();
            if (ack[1] !== 1'b0 || pio_en !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL withdraw_extra got %0d exp 0", extra); end
        checks++; if (shadow !== 32'h0000_00A9) begin errors++; $display("FAIL withdraw_shadow got %h exp %h", shadow, 32'h0000_00A9); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_field_isolation();
        test_contention();
        test_reset_mid_issue();
        test_request_withdrawn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
